// File: rtl/axis_frame_len_stats.sv
// axis_frame_len_stats
// Passive AXI4-Stream frame-length monitor. It counts the bytes of every
// frame seen on a tapped stream and queues one {length, overflow} record per
// completed frame in a small FIFO, which is read out on a valid/ready port.
// It also keeps frame-count, min/max-length and drop statistics. The block
// only observes the stream and never back-pressures it.
//
// Handshake (record port): a record moves when frame_len_valid && frame_len_ready
// on a rising edge. While valid is high and ready is low, frame_len and
// frame_len_overflow hold their value. Valid never drops without a pop.
module axis_frame_len_stats #(
   parameter int DATA_WIDTH  = 64,
   parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
   parameter int KEEP_WIDTH  = (DATA_WIDTH / 8),
   parameter int LEN_WIDTH   = 16,
   parameter int COUNT_WIDTH = 32,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [KEEP_WIDTH-1:0]  monitor_axis_tkeep,
   input  logic                   monitor_axis_tvalid,
   input  logic                   monitor_axis_tready,
   input  logic                   monitor_axis_tlast,
   output logic [LEN_WIDTH-1:0]   frame_len,
   output logic                   frame_len_overflow,
   output logic                   frame_len_valid,
   input  logic                   frame_len_ready,
   input  logic                   stat_clear,
   output logic [COUNT_WIDTH-1:0] stat_frame_count,
   output logic [LEN_WIDTH-1:0]   stat_len_min,
   output logic [LEN_WIDTH-1:0]   stat_len_max,
   output logic [COUNT_WIDTH-1:0] stat_drop_count,
   output logic                   dbg_state
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [LEN_WIDTH-1:0]   LEN_MAX = '1;

   typedef enum logic {S_IDLE = 1'b0, S_IN_FRAME = 1'b1} state_t;

   state_t                state;
   state_t                state_nxt;
   logic [LEN_WIDTH-1:0]  acc;
   logic                  ovf;
   logic [LEN_WIDTH-1:0]  acc_nxt;
   logic                  ovf_nxt;
   logic [LEN_WIDTH:0]    beat_cnt;
   logic [LEN_WIDTH:0]    sum;
   logic                  xfer;
   logic                  complete;

   assign xfer      = monitor_axis_tvalid && monitor_axis_tready;
   assign dbg_state = state;

   // Byte count of the current beat: popcount of tkeep, or 1 without tkeep.
   always_comb begin
      beat_cnt = '0;
      if (KEEP_ENABLE != 0) begin
         for (int i = 0; i < KEEP_WIDTH; i++) begin
            beat_cnt = beat_cnt + {{LEN_WIDTH{1'b0}}, monitor_axis_tkeep[i]};
         end
      end else begin
         beat_cnt = {{LEN_WIDTH{1'b0}}, 1'b1};
      end
   end

   // Frame state register; a reset mid-frame drops the partial frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state: a non-last transfer opens a frame, a last transfer closes it.
   always_comb begin
      state_nxt = state;
      if (xfer) begin
         state_nxt = monitor_axis_tlast ? S_IDLE : S_IN_FRAME;
      end
   end

   // Accumulator datapath: start fresh in IDLE, saturating add in IN_FRAME.
   always_comb begin
      acc_nxt  = acc;
      ovf_nxt  = ovf;
      sum      = '0;
      complete = 1'b0;
      if (xfer) begin
         complete = monitor_axis_tlast;
         if (state == S_IDLE) begin
            acc_nxt = beat_cnt[LEN_WIDTH-1:0];
            ovf_nxt = 1'b0;
         end else begin
            sum = {1'b0, acc} + beat_cnt;
            if (sum[LEN_WIDTH]) begin
               acc_nxt = LEN_MAX;
               ovf_nxt = 1'b1;
            end else begin
               acc_nxt = sum[LEN_WIDTH-1:0];
               ovf_nxt = ovf;
            end
         end
      end
   end

   // Accumulator and sticky overflow only move on transfers.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc <= '0;
         ovf <= 1'b0;
      end else if (xfer) begin
         acc <= acc_nxt;
         ovf <= ovf_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Record FIFO. Pointers carry one extra wrap bit to tell full from empty.
   // ------------------------------------------------------------------
   logic [LEN_WIDTH:0] mem [FIFO_DEPTH];
   logic [AW:0]        wr_ptr;
   logic [AW:0]        rd_ptr;
   logic               fifo_empty;
   logic               fifo_full;
   logic               pop;
   logic               push;
   logic               drop;
   logic [LEN_WIDTH:0] head;

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                       (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop        = frame_len_valid && frame_len_ready;
   // A full FIFO still accepts a record when the head leaves the same cycle.
   assign push       = complete && (!fifo_full || pop);
   assign drop       = complete && fifo_full && !pop;
   assign head       = mem[rd_ptr[AW-1:0]];

   assign frame_len_valid    = !fifo_empty;
   assign frame_len          = fifo_empty ? '0 : head[LEN_WIDTH-1:0];
   assign frame_len_overflow = fifo_empty ? 1'b0 : head[LEN_WIDTH];

   // FIFO pointers advance on push and pop.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   // FIFO storage; contents are don't-care until written, outputs are gated.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= {ovf_nxt, acc_nxt};
      end
   end

   // ------------------------------------------------------------------
   // Statistics. A clear is applied first, then any same-cycle completion.
   // ------------------------------------------------------------------
   logic [COUNT_WIDTH-1:0] fc_base;
   logic [COUNT_WIDTH-1:0] drop_base;
   logic [LEN_WIDTH-1:0]   min_base;
   logic [LEN_WIDTH-1:0]   max_base;
   logic [COUNT_WIDTH-1:0] fc_nxt;
   logic [COUNT_WIDTH-1:0] drop_nxt;
   logic [LEN_WIDTH-1:0]   min_nxt;
   logic [LEN_WIDTH-1:0]   max_nxt;

   // Combine clear and completion into the next statistics values.
   always_comb begin
      fc_base   = stat_clear ? '0 : stat_frame_count;
      drop_base = stat_clear ? '0 : stat_drop_count;
      min_base  = stat_clear ? LEN_MAX : stat_len_min;
      max_base  = stat_clear ? '0 : stat_len_max;
      fc_nxt    = fc_base;
      drop_nxt  = drop_base;
      min_nxt   = min_base;
      max_nxt   = max_base;
      if (complete) begin
         if (fc_base != CNT_MAX) begin
            fc_nxt = fc_base + 1'b1;
         end
         if (acc_nxt < min_base) begin
            min_nxt = acc_nxt;
         end
         if (acc_nxt > max_base) begin
            max_nxt = acc_nxt;
         end
      end
      if (drop && (drop_base != CNT_MAX)) begin
         drop_nxt = drop_base + 1'b1;
      end
   end

   // Statistics registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_frame_count <= '0;
         stat_drop_count  <= '0;
         stat_len_min     <= LEN_MAX;
         stat_len_max     <= '0;
      end else begin
         stat_frame_count <= fc_nxt;
         stat_drop_count  <= drop_nxt;
         stat_len_min     <= min_nxt;
         stat_len_max     <= max_nxt;
      end
   end

endmodule

// File: tb/tb_axis_frame_len_stats.sv
// Directed bench for axis_frame_len_stats: a 16-bit-length instance and an
// 8-bit-length instance watch the same stream.
module tb_axis_frame_len_stats;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  tkeep = '0;
  logic        tvalid = 1'b0;
  logic        tready = 1'b1;
  logic        tlast = 1'b0;
  logic        rdy = 1'b0;
  logic        rdy8 = 1'b1;
  logic        stat_clear = 1'b0;

  logic [15:0] frame_len;
  logic        frame_len_overflow;
  logic        frame_len_valid;
  logic [31:0] stat_frame_count;
  logic [15:0] stat_len_min;
  logic [15:0] stat_len_max;
  logic [31:0] stat_drop_count;
  logic        dbg_state;

  logic [7:0]  frame_len8;
  logic        frame_len_overflow8;
  logic        frame_len_valid8;
  logic [31:0] stat_frame_count8;
  logic [7:0]  stat_len_min8;
  logic [7:0]  stat_len_max8;
  logic [31:0] stat_drop_count8;
  logic        dbg_state8;

  int total = 0;
  int bad = 0;

  axis_frame_len_stats #(.DATA_WIDTH(64), .LEN_WIDTH(16), .COUNT_WIDTH(32), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .monitor_axis_tkeep(tkeep), .monitor_axis_tvalid(tvalid),
    .monitor_axis_tready(tready), .monitor_axis_tlast(tlast),
    .frame_len(frame_len), .frame_len_overflow(frame_len_overflow),
    .frame_len_valid(frame_len_valid), .frame_len_ready(rdy),
    .stat_clear(stat_clear), .stat_frame_count(stat_frame_count),
    .stat_len_min(stat_len_min), .stat_len_max(stat_len_max),
    .stat_drop_count(stat_drop_count), .dbg_state(dbg_state)
  );

  axis_frame_len_stats #(.DATA_WIDTH(64), .LEN_WIDTH(8), .COUNT_WIDTH(32), .FIFO_DEPTH(4)) dut8 (
    .clk(clk), .rst(rst),
    .monitor_axis_tkeep(tkeep), .monitor_axis_tvalid(tvalid),
    .monitor_axis_tready(tready), .monitor_axis_tlast(tlast),
    .frame_len(frame_len8), .frame_len_overflow(frame_len_overflow8),
    .frame_len_valid(frame_len_valid8), .frame_len_ready(rdy8),
    .stat_clear(stat_clear), .stat_frame_count(stat_frame_count8),
    .stat_len_min(stat_len_min8), .stat_len_max(stat_len_max8),
    .stat_drop_count(stat_drop_count8), .dbg_state(dbg_state8)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One beat on the monitored stream; outputs are sampled 1 ns after the edge.
  task automatic beat(input logic [7:0] keep, input logic last);
    tkeep  = keep;
    tlast  = last;
    tvalid = 1'b1;
    @(posedge clk); #1;
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Pop the head record of the 16-bit instance.
  task automatic pop;
    rdy = 1'b1;
    @(posedge clk); #1;
    rdy = 1'b0;
  endtask

  task automatic clear_pulse;
    stat_clear = 1'b1;
    @(posedge clk); #1;
    stat_clear = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_valid"}, 32'(frame_len_valid), 32'd0);
    check({tag, "_len"},   32'(frame_len), 32'd0);
    check({tag, "_ovf"},   32'(frame_len_overflow), 32'd0);
    check({tag, "_fc"},    stat_frame_count, 32'd0);
    check({tag, "_drop"},  stat_drop_count, 32'd0);
    check({tag, "_max"},   32'(stat_len_max), 32'd0);
    check({tag, "_min"},   32'(stat_len_min), 32'h0000_ffff);
    check({tag, "_valid8"}, 32'(frame_len_valid8), 32'd0);
  endtask

  initial begin
    // reset
    rst = 1'b1;
    idle(3);
    check_reset_vals("rst0");
    rst = 1'b0;
    idle(1);

    // 8 + 8 + 4 byte frame
    beat(8'hFF, 1'b0);
    beat(8'hFF, 1'b0);
    check("t1_novalid", 32'(frame_len_valid), 32'd0);
    beat(8'h0F, 1'b1);
    check("t1_valid", 32'(frame_len_valid), 32'd1);
    check("t1_len", 32'(frame_len), 32'd20);
    check("t1_ovf", 32'(frame_len_overflow), 32'd0);
    check("t1_fc", stat_frame_count, 32'd1);
    check("t1_min", 32'(stat_len_min), 32'd20);
    check("t1_max", 32'(stat_len_max), 32'd20);
    pop();
    check("t1_empty", 32'(frame_len_valid), 32'd0);

    // sparse keep and all-zero keep
    clear_pulse();
    check("clr_fc", stat_frame_count, 32'd0);
    check("clr_min", 32'(stat_len_min), 32'h0000_ffff);
    check("clr_max", 32'(stat_len_max), 32'd0);
    beat(8'h81, 1'b1);
    check("t2_len_a", 32'(frame_len), 32'd2);
    beat(8'h00, 1'b1);
    check("t2_head_hold", 32'(frame_len), 32'd2);
    check("t2_fc", stat_frame_count, 32'd2);
    check("t2_min", 32'(stat_len_min), 32'd0);
    check("t2_max", 32'(stat_len_max), 32'd2);
    pop();
    check("t2_valid_b", 32'(frame_len_valid), 32'd1);
    check("t2_len_b", 32'(frame_len), 32'd0);
    pop();
    check("t2_empty", 32'(frame_len_valid), 32'd0);

    // 40 x 8 bytes: saturates the 8-bit instance, fits the 16-bit one
    for (int i = 0; i < 40; i++) begin
      beat(8'hFF, (i == 39));
    end
    check("t3_valid8", 32'(frame_len_valid8), 32'd1);
    check("t3_len8", 32'(frame_len8), 32'd255);
    check("t3_ovf8", 32'(frame_len_overflow8), 32'd1);
    check("t3_len16", 32'(frame_len), 32'd320);
    check("t3_ovf16", 32'(frame_len_overflow), 32'd0);
    pop();
    beat(8'hFF, 1'b1);
    check("t3_len8_next", 32'(frame_len8), 32'd8);
    check("t3_ovf8_next", 32'(frame_len_overflow8), 32'd0);
    pop();

    // six back-to-back single-beat frames into a stalled depth-4 FIFO
    clear_pulse();
    beat(8'h01, 1'b1);
    beat(8'h03, 1'b1);
    beat(8'h07, 1'b1);
    beat(8'h0F, 1'b1);
    beat(8'h1F, 1'b1);
    beat(8'h3F, 1'b1);
    check("t4_fc", stat_frame_count, 32'd6);
    check("t4_drop", stat_drop_count, 32'd2);
    check("t4_min", 32'(stat_len_min), 32'd1);
    check("t4_max", 32'(stat_len_max), 32'd6);
    check("t4_head", 32'(frame_len), 32'd1);
    idle(2);
    check("t4_stall_valid", 32'(frame_len_valid), 32'd1);
    check("t4_stall_len", 32'(frame_len), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("t4_drain%0d", i), 32'(frame_len), 32'(i));
      pop();
    end
    check("t4_empty", 32'(frame_len_valid), 32'd0);

    // clear on the same cycle as a 24-byte tlast
    beat(8'hFF, 1'b0);
    beat(8'hFF, 1'b0);
    stat_clear = 1'b1;
    beat(8'hFF, 1'b1);
    stat_clear = 1'b0;
    check("t5_fc", stat_frame_count, 32'd1);
    check("t5_min", 32'(stat_len_min), 32'd24);
    check("t5_max", 32'(stat_len_max), 32'd24);
    check("t5_drop", stat_drop_count, 32'd0);
    check("t5_len", 32'(frame_len), 32'd24);
    pop();

    // reset mid-frame with a record still queued
    beat(8'h01, 1'b1);
    beat(8'hFF, 1'b0);
    beat(8'hFF, 1'b0);
    rst = 1'b1;
    idle(1);
    check_reset_vals("rst1");
    idle(1);
    rst = 1'b0;
    beat(8'h03, 1'b1);
    check("t6_valid", 32'(frame_len_valid), 32'd1);
    check("t6_len", 32'(frame_len), 32'd2);
    check("t6_fc", stat_frame_count, 32'd1);
    check("t6_min", 32'(stat_len_min), 32'd2);
    pop();
    check("t6_empty", 32'(frame_len_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
